vram_arbiter: RTL and testbench

//  Shares one single-port synchronous video RAM between the VGA scan-out fetch and the keyboard/text writer.

---
 rtl/vram_pkg.sv | 26 ++
 rtl/vram_wr_fifo.sv | 59 +++++
 rtl/vram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared types and constants for the video RAM arbiter.
//   ADDR_W / DATA_W : RAM address and data widths
//   DISP_LAT        : cycles from display address to registered display data
//   state_e         : arbiter FSM states
//   wr_entry_t      : one queued host write (address + data)
// -----------------------------------------------------------------------------
package vram_pkg;

   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 8;
   localparam int DISP_LAT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// -----------------------------------------------------------------------------
// vram_wr_fifo
// Synchronous FIFO holding pending host writes until a blanking cycle.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_din  : enqueue one entry (ignored when full)
//   i_pop          : dequeue the head (ignored when empty)
//   o_dout         : current head entry (valid when !o_empty)
//   o_empty        : no entries held
//   o_count        : current occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
// -----------------------------------------------------------------------------
module vram_wr_fifo
   import vram_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  wr_entry_t        i_din,
   input  logic             i_pop,
   output wr_entry_t        o_dout,
   output logic             o_empty,
   output logic [PTR_W-1:0] o_count
);

   wr_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_count   = r_wptr - r_rptr;
   assign o_empty   = (r_wptr == r_rptr);
   assign w_full    = (o_count == PTR_W'(DEPTH));
   assign w_do_push = i_push & ~w_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_dout    = r_mem[r_rptr[PTR_W-2:0]];

   // NOTE: the storage array is deliberately not reset; the pointers alone
   // decide which entries are meaningful, so resetting data would only cost logic.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr[PTR_W-2:0]] <= i_din;
   end

   // NOTE: registers are written with <= so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous video RAM between VGA scan-out and the
// host text writer. Active video always reads for the display; queued host
// writes and bulk clears only use blanking cycles.
//   iVGA_CLK, iRST_n          : pixel clock, asynchronous active-low reset
//   iBLANK_n                  : 1 = active video, display owns the RAM port
//   iDisp_addr                : display fetch address
//   oDisp_data, oDisp_valid   : fetched word, DISP_LAT cycles after address
//   iWr_req/addr/data         : host write, accepted when oWr_ready=1
//   oWr_ready, oWr_overflow   : queue has room / sticky dropped-write flag
//   iClr_req, oClr_busy       : clear pulse / clear pending or running
//   oRam_addr/wdata/we        : registered RAM command
//   iRam_rdata                : RAM read data, one cycle after the address
// -----------------------------------------------------------------------------
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int                MEM_WORDS  = 307200,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0] CLR_VALUE  = 8'h00
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic              iBLANK_n,
   input  logic [ADDR_W-1:0] iDisp_addr,
   output logic [DATA_W-1:0] oDisp_data,
   output logic              oDisp_valid,
   input  logic              iWr_req,
   input  logic [ADDR_W-1:0] iWr_addr,
   input  logic [DATA_W-1:0] iWr_data,
   output logic              oWr_ready,
   output logic              oWr_overflow,
   input  logic              iClr_req,
   output logic              oClr_busy,
   output logic [ADDR_W-1:0] oRam_addr,
   output logic [DATA_W-1:0] oRam_wdata,
   output logic              oRam_we,
   input  logic [DATA_W-1:0] iRam_rdata
);

   localparam int                PTR_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MEM_WORDS - 1);

   state_e              r_state,     w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_cnt,   w_clr_cnt_nxt;
   logic                r_clr_busy,  w_clr_busy_nxt;
   logic                r_wr_ready;
   logic                r_overflow;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic [DATA_W-1:0]   r_ram_wdata;
   logic                r_ram_we;
   logic [DISP_LAT-2:0] r_vld_pipe;
   logic                r_disp_valid;
   logic [DATA_W-1:0]   r_disp_data;

   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic [PTR_W-1:0]    w_count;
   logic [PTR_W-1:0]    w_count_nxt;
   wr_entry_t           w_din;
   wr_entry_t           w_head;
   logic                w_clr_pend;
   logic                w_wr_en;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic [DATA_W-1:0]   w_wr_data;

   assign w_din       = '{addr: iWr_addr, data: iWr_data};
   assign w_push      = iWr_req & r_wr_ready;
   assign w_count_nxt = w_count + PTR_W'(w_push) - PTR_W'(w_pop);
   // A request while busy is simply absorbed by the already-set busy flag.
   assign w_clr_pend  = r_clr_busy | iClr_req;

   vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .i_clk   (iVGA_CLK),
      .i_rst_n (iRST_n),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // NOTE: every variable gets a default before the case so no branch can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_clr_cnt_nxt  = r_clr_cnt;
      w_clr_busy_nxt = w_clr_pend;
      w_pop          = 1'b0;
      w_wr_en        = 1'b0;
      w_wr_addr      = w_head.addr;
      w_wr_data      = w_head.data;
      case (r_state)
         IDLE: begin
            // Queued writes always go ahead of a clear requested after them.
            if (w_clr_pend && w_empty) w_state_nxt = CLEAR;
            else if (!w_empty)         w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!iBLANK_n) begin
               w_pop   = 1'b1;
               w_wr_en = 1'b1;
               if (w_count == PTR_W'(1) && !w_push)
                  w_state_nxt = w_clr_pend ? CLEAR : IDLE;
            end
         end
         CLEAR: begin
            // Writes pushed now wait in the queue and land after the clear.
            if (!iBLANK_n) begin
               w_wr_en   = 1'b1;
               w_wr_addr = r_clr_cnt;
               w_wr_data = CLR_VALUE;
               if (r_clr_cnt == CLR_LAST) begin
                  w_clr_cnt_nxt  = '0;
                  w_clr_busy_nxt = 1'b0;
                  w_state_nxt    = IDLE;
               end else begin
                  w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_state    <= IDLE;
         r_clr_cnt  <= '0;
         r_clr_busy <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_cnt  <= w_clr_cnt_nxt;
         r_clr_busy <= w_clr_busy_nxt;
      end
   end

   // Ready is computed from next occupancy so a same-cycle pop frees a slot.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_wr_ready <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_wr_ready <= (w_count_nxt != PTR_W'(FIFO_DEPTH));
         if (iWr_req && !r_wr_ready) r_overflow <= 1'b1;
      end
   end

   // One RAM op per edge; display reads win whenever video is active.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_ram_we    <= 1'b0;
      end else if (iBLANK_n) begin
         r_ram_addr <= iDisp_addr;
         r_ram_we   <= 1'b0;
      end else if (w_wr_en) begin
         r_ram_addr  <= w_wr_addr;
         r_ram_wdata <= w_wr_data;
         r_ram_we    <= 1'b1;
      end else begin
         r_ram_we <= 1'b0;
      end
   end

   // Valid tracks iBLANK_n through address register and RAM read stages.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_vld_pipe   <= '0;
         r_disp_valid <= 1'b0;
         r_disp_data  <= '0;
      end else begin
         r_vld_pipe   <= {r_vld_pipe[DISP_LAT-3:0], iBLANK_n};
         r_disp_valid <= r_vld_pipe[DISP_LAT-2];
         if (r_vld_pipe[DISP_LAT-2]) r_disp_data <= iRam_rdata;
      end
   end

   assign oDisp_data   = r_disp_data;
   assign oDisp_valid  = r_disp_valid;
   assign oWr_ready    = r_wr_ready;
   assign oWr_overflow = r_overflow;
   assign oClr_busy    = r_clr_busy;
   assign oRam_addr    = r_ram_addr;
   assign oRam_wdata   = r_ram_wdata;
   assign oRam_we      = r_ram_we;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed stimulus with a scoreboard: expected RAM writes and display words
// are queued as stimulus is issued; a negedge monitor pops and compares them
// whenever the DUT presents a write or a valid display word.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        blank_n = 1'b0;
   logic [18:0] disp_addr = '0;
   logic [7:0]  disp_data;
   logic        disp_valid;
   logic        wr_req = 1'b0;
   logic [18:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_ready;
   logic        wr_overflow;
   logic        clr_req = 1'b0;
   logic        clr_busy;
   logic [18:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [7:0]  ram_rdata = '0;

   vram_arbiter #(.MEM_WORDS(16), .FIFO_DEPTH(4), .CLR_VALUE(8'h00)) dut (
      .iVGA_CLK     (clk),
      .iRST_n       (rst_n),
      .iBLANK_n     (blank_n),
      .iDisp_addr   (disp_addr),
      .oDisp_data   (disp_data),
      .oDisp_valid  (disp_valid),
      .iWr_req      (wr_req),
      .iWr_addr     (wr_addr),
      .iWr_data     (wr_data),
      .oWr_ready    (wr_ready),
      .oWr_overflow (wr_overflow),
      .iClr_req     (clr_req),
      .oClr_busy    (clr_busy),
      .oRam_addr    (ram_addr),
      .oRam_wdata   (ram_wdata),
      .oRam_we      (ram_we),
      .iRam_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM model: read data is the low byte of the address sampled last edge.
   always @(posedge clk) ram_rdata <= ram_addr[7:0];

   typedef struct {
      logic [18:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_disp[$];
   wr_t        got_wr;
   logic [7:0] got_disp;
   logic       prev_blank = 1'b1;
   int         n_checks = 0;
   int         n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic exp_w(input logic [18:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_wr.push_back(e);
   endtask

   // One clock cycle of stimulus; active-video cycles queue a display word.
   task automatic step(input logic b, input logic [18:0] da, input logic w,
                       input logic [18:0] wa, input logic [7:0] wd, input logic c);
      blank_n   = b;
      disp_addr = da;
      wr_req    = w;
      wr_addr   = wa;
      wr_data   = wd;
      clr_req   = c;
      if (b) exp_disp.push_back(da[7:0]);
      @(posedge clk);
      #1;
   endtask

   // Monitor
   always @(negedge clk) begin
      if (ram_we) begin
         check("wr_in_active_cycle", {31'd0, prev_blank}, 32'd0);
         if (exp_wr.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_wr: got addr %0h data %0h, expected no write", ram_addr, ram_wdata);
         end else begin
            got_wr = exp_wr.pop_front();
            check("wr_addr", {13'd0, ram_addr}, {13'd0, got_wr.addr});
            check("wr_data", {24'd0, ram_wdata}, {24'd0, got_wr.data});
         end
      end
      if (disp_valid) begin
         if (exp_disp.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_disp: got data %0h, expected no valid", disp_data);
         end else begin
            got_disp = exp_disp.pop_front();
            check("disp_data", {24'd0, disp_data}, {24'd0, got_disp});
         end
      end
      prev_blank = blank_n;
   end

   initial begin
      // 1. Reset with random inputs
      repeat (4) begin
         blank_n   = 1'($urandom);
         disp_addr = 19'($urandom);
         wr_req    = 1'($urandom);
         wr_addr   = 19'($urandom);
         wr_data   = 8'($urandom);
         clr_req   = 1'($urandom);
         @(posedge clk);
         #1;
         check("rst_we",       {31'd0, ram_we},      32'd0);
         check("rst_addr",     {13'd0, ram_addr},    32'd0);
         check("rst_wdata",    {24'd0, ram_wdata},   32'd0);
         check("rst_valid",    {31'd0, disp_valid},  32'd0);
         check("rst_data",     {24'd0, disp_data},   32'd0);
         check("rst_ready",    {31'd0, wr_ready},    32'd1);
         check("rst_overflow", {31'd0, wr_overflow}, 32'd0);
         check("rst_busy",     {31'd0, clr_busy},    32'd0);
      end
      wr_req = 1'b0;
      clr_req = 1'b0;
      rst_n = 1'b1;
      step(1, 19'd42, 0, 0, 0, 0);
      check("rel_addr", {13'd0, ram_addr}, 32'd42);
      check("rel_we",   {31'd0, ram_we},   32'd0);

      // 2. Display latency
      repeat (3) step(0, 0, 0, 0, 0, 0);
      step(1, 19'd100, 0, 0, 0, 0);
      check("lat_t1_valid", {31'd0, disp_valid}, 32'd0);
      step(1, 19'd101, 0, 0, 0, 0);
      check("lat_t2_valid", {31'd0, disp_valid}, 32'd0);
      step(1, 19'd102, 0, 0, 0, 0);
      check("lat_t3_valid", {31'd0, disp_valid}, 32'd1);
      check("lat_t3_data",  {24'd0, disp_data},  32'd100);
      step(1, 19'd103, 0, 0, 0, 0);

      // 3. Writes deferred to blanking, in order, none on active cycles
      exp_w(19'd5, 8'hA1);
      exp_w(19'd6, 8'hA2);
      exp_w(19'd7, 8'hA3);
      step(1, 19'd200, 1, 19'd5, 8'hA1, 0);
      step(1, 19'd201, 1, 19'd6, 8'hA2, 0);
      step(1, 19'd202, 1, 19'd7, 8'hA3, 0);
      step(1, 19'd203, 0, 0, 0, 0);
      step(1, 19'd204, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 19'd205, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 19'd206, 0, 0, 0, 0);
      check("t3_writes_left", exp_wr.size(), 32'd0);

      // 4. Overflow with a 4-deep queue
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_w(19'h40 + 19'(i), 8'hD0 + 8'(i));
         step(1, 19'd300 + 19'(i), 1, 19'h40 + 19'(i), 8'hD0 + 8'(i), 0);
         if (i == 3) begin
            check("t4_ready_full",   {31'd0, wr_ready},    32'd0);
            check("t4_no_overflow",  {31'd0, wr_overflow}, 32'd0);
         end
      end
      check("t4_overflow", {31'd0, wr_overflow}, 32'd1);
      repeat (4) step(0, 0, 0, 0, 0, 0);
      step(1, 19'd310, 0, 0, 0, 0);
      check("t4_writes_left",     exp_wr.size(),         32'd0);
      check("t4_ready_again",     {31'd0, wr_ready},     32'd1);
      check("t4_overflow_sticky", {31'd0, wr_overflow},  32'd1);

      // 5. Clear ordering: prior writes, clear 0..15, then later write
      exp_w(19'h20, 8'hB1);
      exp_w(19'h21, 8'hB2);
      for (int a = 0; a < 16; a++) exp_w(19'(a), 8'h00);
      exp_w(19'h22, 8'hC3);
      step(1, 19'd400, 1, 19'h20, 8'hB1, 0);
      step(1, 19'd401, 1, 19'h21, 8'hB2, 0);
      step(1, 19'd402, 0, 0, 0, 1);
      check("t5_busy_set", {31'd0, clr_busy}, 32'd1);
      for (int i = 0; i < 25; i++) begin
         step(0, 0, (i == 5), 19'h22, 8'hC3, 0);
         check("t5_busy", {31'd0, clr_busy}, {31'd0, (i < 17)});
      end
      step(1, 19'd403, 0, 0, 0, 0);
      check("t5_writes_left", exp_wr.size(), 32'd0);

      // 6. Async reset in the middle of a clear
      for (int a = 0; a < 7; a++) exp_w(19'(a), 8'h00);
      step(1, 19'd500, 0, 0, 0, 1);
      repeat (7) step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      check("t6_writes_before_rst", exp_wr.size(), 32'd0);
      rst_n = 1'b0;
      #1;
      check("t6_we_rst",   {31'd0, ram_we},   32'd0);
      check("t6_busy_rst", {31'd0, clr_busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) step(0, 0, 0, 0, 0, 0);
      check("t6_busy_after",     {31'd0, clr_busy},    32'd0);
      check("t6_overflow_clr",   {31'd0, wr_overflow}, 32'd0);
      check("t6_ready_after",    {31'd0, wr_ready},    32'd1);
      check("disp_left",         exp_disp.size(),      32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
